// File: rtl/pa_icache_pkg.sv
// Shared i-cache definitions: line geometry, loader states and the cacheline type.
`default_nettype none

package pa_icache_pkg;
  localparam int LINE_BYTES = 32;
  localparam int LINE_W     = LINE_BYTES * 8;
  localparam int ADDR_W     = 8;
  // One extra count value so a full line (count == LINE_BYTES) is representable.
  localparam int CNT_W      = $clog2(LINE_BYTES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    FULL  = 2'd2,
    ISSUE = 2'd3
  } loader_state_t;

  typedef logic [LINE_W-1:0] cacheline_t;
endpackage

`default_nettype wire

// File: rtl/line_byte_assembler.sv
// Byte-lane write decode, cacheline data register and fill count for the line loader.
`default_nettype none

module line_byte_assembler
  import pa_icache_pkg::*;
(
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             clear_i,
  input  logic             wr_i,
  input  logic [7:0]       byte_i,
  output cacheline_t       data_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o
);

  logic [CNT_W-1:0]      count_q;
  logic [CNT_W-1:0]      count_d;
  cacheline_t            data_q;
  logic [LINE_BYTES-1:0] lane_we;
  logic                  wr_ok;

  assign full_o = (count_q == CNT_W'(LINE_BYTES));
  assign wr_ok  = wr_i && !full_o;

  generate
    for (genvar g = 0; g < LINE_BYTES; g++) begin : g_lane
      assign lane_we[g] = wr_ok && (count_q == CNT_W'(g));
    end
  endgenerate

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (wr_ok) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      count_q <= '0;
      data_q  <= '0;
    end else begin
      count_q <= count_d;
      if (clear_i) begin
        data_q <= '0;
      end else begin
        for (int i = 0; i < LINE_BYTES; i++) begin
          if (lane_we[i]) data_q[8*i +: 8] <= byte_i;
        end
      end
    end
  end

  assign data_o  = data_q;
  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/icache_line_loader.sv
// Byte-serial cacheline loader: collects an address byte plus LINE_BYTES data bytes
// and issues the assembled line to the i-cache write port over valid/ready.
`default_nettype none

module icache_line_loader
  import pa_icache_pkg::*;
(
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_data_i,
  input  logic              is_address_i,
  input  logic              commit_i,
  output logic              byte_ready_o,
  output logic              line_valid_o,
  input  logic              line_ready_i,
  output logic [ADDR_W-1:0] line_addr_o,
  output cacheline_t        line_data_o,
  output logic              commit_err_o,
  output logic              overflow_o
);

  loader_state_t     state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_q, err_d;
  logic              ovf_q, ovf_d;
  logic              asm_clear, asm_wr;
  logic [CNT_W-1:0]  asm_count;
  logic              asm_full;
  logic              byte_acc, addr_acc, data_acc, commit_acc;

  assign byte_ready_o = (state_q != ISSUE);
  assign byte_acc     = byte_valid_i && byte_ready_o;
  assign addr_acc     = byte_acc && is_address_i;
  assign data_acc     = byte_acc && !is_address_i;
  // A byte in the same cycle as a commit takes priority; the commit is dropped silently.
  assign commit_acc   = commit_i && byte_ready_o && !byte_valid_i;

  line_byte_assembler u_asm (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .clear_i (asm_clear),
    .wr_i    (asm_wr),
    .byte_i  (byte_data_i),
    .data_o  (line_data_o),
    .count_o (asm_count),
    .full_o  (asm_full)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    err_d     = 1'b0;
    ovf_d     = ovf_q;
    asm_clear = 1'b0;
    asm_wr    = 1'b0;
    case (state_q)
      IDLE: begin
        if (addr_acc) begin
          addr_d    = byte_data_i;
          asm_clear = 1'b1;
          state_d   = FILL;
        end else if (commit_acc) begin
          err_d = 1'b1;
        end
      end
      FILL: begin
        if (addr_acc) begin
          addr_d    = byte_data_i;
          asm_clear = 1'b1;
        end else if (data_acc) begin
          asm_wr = 1'b1;
          if (asm_count == CNT_W'(LINE_BYTES - 1)) state_d = FULL;
        end else if (commit_acc) begin
          err_d = 1'b1;
        end
      end
      FULL: begin
        if (addr_acc) begin
          addr_d    = byte_data_i;
          asm_clear = 1'b1;
          state_d   = FILL;
        end else if (data_acc) begin
          ovf_d = 1'b1;
        end else if (commit_acc) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (line_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
    end
  end

  assign line_valid_o = (state_q == ISSUE);
  assign line_addr_o  = addr_q;
  assign commit_err_o = err_q;
  assign overflow_o   = ovf_q;

`ifndef SYNTHESIS
  a_no_byte_with_commit: assert property (@(posedge clock_i) disable iff (!reset_i)
    !(byte_valid_i && commit_i && byte_ready_o));
  a_full_matches_state: assert property (@(posedge clock_i) disable iff (!reset_i)
    (state_q == FULL) |-> asm_full);
`endif

endmodule

`default_nettype wire

// File: tb/tb_icache_line_loader.sv
// Directed self-checking bench for icache_line_loader.
`default_nettype none

module tb_icache_line_loader;
  import pa_icache_pkg::*;

  logic              clock_i = 1'b0;
  logic              reset_i = 1'b0;
  logic              byte_valid_i = 1'b0;
  logic [7:0]        byte_data_i = 8'h00;
  logic              is_address_i = 1'b0;
  logic              commit_i = 1'b0;
  logic              byte_ready_o;
  logic              line_valid_o;
  logic              line_ready_i = 1'b0;
  logic [ADDR_W-1:0] line_addr_o;
  cacheline_t        line_data_o;
  logic              commit_err_o;
  logic              overflow_o;

  int total = 0;
  int bad   = 0;

  always #5 clock_i = ~clock_i;

  icache_line_loader dut (
    .clock_i      (clock_i),
    .reset_i      (reset_i),
    .byte_valid_i (byte_valid_i),
    .byte_data_i  (byte_data_i),
    .is_address_i (is_address_i),
    .commit_i     (commit_i),
    .byte_ready_o (byte_ready_o),
    .line_valid_o (line_valid_o),
    .line_ready_i (line_ready_i),
    .line_addr_o  (line_addr_o),
    .line_data_o  (line_data_o),
    .commit_err_o (commit_err_o),
    .overflow_o   (overflow_o)
  );

  // All drivers start 1 time unit after a rising edge and return there.
  task automatic put(input logic [7:0] b, input logic a);
    byte_valid_i = 1'b1;
    byte_data_i  = b;
    is_address_i = a;
    @(posedge clock_i); #1;
    byte_valid_i = 1'b0;
    is_address_i = 1'b0;
  endtask

  task automatic do_commit();
    commit_i = 1'b1;
    @(posedge clock_i); #1;
    commit_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_i = 1'b0;
    repeat (3) @(posedge clock_i);
    @(negedge clock_i);
    reset_i = 1'b1;
    @(posedge clock_i); #1;
    total++; if (byte_ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", byte_ready_o); end
    total++; if (line_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", line_valid_o); end
    total++; if (line_addr_o !== 8'h00) begin bad++; $display("FAIL reset_addr got=%h want=00", line_addr_o); end
    total++; if (line_data_o !== '0) begin bad++; $display("FAIL reset_data got=%h want=0", line_data_o); end
    total++; if ({commit_err_o, overflow_o} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b want=00", {commit_err_o, overflow_o}); end
  endtask

  task automatic test_basic();
    cacheline_t exp;
    int hi;
    line_ready_i = 1'b1;
    put(8'h03, 1'b1);
    for (int i = 0; i < LINE_BYTES; i++) begin
      put(8'(i), 1'b0);
      exp[8*i +: 8] = 8'(i);
    end
    do_commit();
    total++; if (line_valid_o !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b want=1", line_valid_o); end
    total++; if (line_addr_o !== 8'h03) begin bad++; $display("FAIL basic_addr got=%h want=03", line_addr_o); end
    total++; if (line_data_o[7:0] !== 8'h00) begin bad++; $display("FAIL basic_byte0 got=%h want=00", line_data_o[7:0]); end
    total++; if (line_data_o[255:248] !== 8'h1F) begin bad++; $display("FAIL basic_byte31 got=%h want=1f", line_data_o[255:248]); end
    total++; if (line_data_o !== exp) begin bad++; $display("FAIL basic_line got=%h want=%h", line_data_o, exp); end
    hi = 0;
    for (int k = 0; k < 4; k++) begin
      if (line_valid_o === 1'b1) hi++;
      @(posedge clock_i); #1;
    end
    total++; if (hi !== 1) begin bad++; $display("FAIL basic_valid_cycles got=%0d want=1", hi); end
    total++; if (byte_ready_o !== 1'b1) begin bad++; $display("FAIL basic_ready_after got=%b want=1", byte_ready_o); end
    // Line data persists after the return to IDLE.
    total++; if (line_data_o !== exp) begin bad++; $display("FAIL basic_data_kept got=%h want=%h", line_data_o, exp); end
  endtask

  task automatic test_backpressure();
    cacheline_t exp;
    line_ready_i = 1'b0;
    put(8'h2A, 1'b1);
    for (int i = 0; i < LINE_BYTES; i++) begin
      put(8'hA0 ^ 8'(i), 1'b0);
      exp[8*i +: 8] = 8'hA0 ^ 8'(i);
    end
    do_commit();
    for (int k = 0; k < 6; k++) begin
      total++; if (line_valid_o !== 1'b1 || byte_ready_o !== 1'b0) begin bad++; $display("FAIL bp_hold k=%0d valid=%b ready=%b want 1/0", k, line_valid_o, byte_ready_o); end
      total++; if (line_data_o !== exp || line_addr_o !== 8'h2A) begin bad++; $display("FAIL bp_stable k=%0d addr=%h want=2a", k, line_addr_o); end
      if (k == 5) line_ready_i = 1'b1;
      @(posedge clock_i); #1;
    end
    total++; if (line_valid_o !== 1'b0 || byte_ready_o !== 1'b1) begin bad++; $display("FAIL bp_idle valid=%b ready=%b want 0/1", line_valid_o, byte_ready_o); end
  endtask

  task automatic test_commit_err();
    cacheline_t exp;
    line_ready_i = 1'b1;
    put(8'h01, 1'b1);
    for (int i = 0; i < 10; i++) begin
      put(8'h30 + 8'(i), 1'b0);
      exp[8*i +: 8] = 8'h30 + 8'(i);
    end
    do_commit();
    total++; if (commit_err_o !== 1'b1) begin bad++; $display("FAIL err_pulse got=%b want=1", commit_err_o); end
    total++; if (line_valid_o !== 1'b0) begin bad++; $display("FAIL err_no_valid got=%b want=0", line_valid_o); end
    @(posedge clock_i); #1;
    total++; if (commit_err_o !== 1'b0) begin bad++; $display("FAIL err_one_cycle got=%b want=0", commit_err_o); end
    for (int i = 10; i < LINE_BYTES; i++) begin
      put(8'h30 + 8'(i), 1'b0);
      exp[8*i +: 8] = 8'h30 + 8'(i);
    end
    do_commit();
    total++; if (line_valid_o !== 1'b1 || line_addr_o !== 8'h01) begin bad++; $display("FAIL err_issue valid=%b addr=%h want 1/01", line_valid_o, line_addr_o); end
    total++; if (line_data_o !== exp) begin bad++; $display("FAIL err_line got=%h want=%h", line_data_o, exp); end
    @(posedge clock_i); #1;
  endtask

  task automatic test_overflow();
    cacheline_t exp;
    line_ready_i = 1'b1;
    put(8'h09, 1'b1);
    for (int i = 0; i < LINE_BYTES; i++) begin
      put(8'h40 + 8'(i), 1'b0);
      exp[8*i +: 8] = 8'h40 + 8'(i);
    end
    total++; if (overflow_o !== 1'b0) begin bad++; $display("FAIL ovf_early got=%b want=0", overflow_o); end
    put(8'hEE, 1'b0);
    total++; if (overflow_o !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b want=1", overflow_o); end
    do_commit();
    total++; if (line_valid_o !== 1'b1 || line_data_o !== exp) begin bad++; $display("FAIL ovf_line valid=%b got=%h want=%h", line_valid_o, line_data_o, exp); end
    repeat (2) @(posedge clock_i); #1;
    total++; if (overflow_o !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b want=1", overflow_o); end
  endtask

  task automatic test_restart();
    cacheline_t exp;
    line_ready_i = 1'b1;
    put(8'h05, 1'b1);
    for (int i = 0; i < 20; i++) put(8'h11, 1'b0);
    put(8'h07, 1'b1);
    total++; if (line_data_o !== '0 || line_addr_o !== 8'h07) begin bad++; $display("FAIL rst_clear addr=%h want=07", line_addr_o); end
    for (int i = 0; i < LINE_BYTES; i++) begin
      put(8'h80 + 8'(i), 1'b0);
      exp[8*i +: 8] = 8'h80 + 8'(i);
    end
    do_commit();
    total++; if (line_valid_o !== 1'b1 || line_addr_o !== 8'h07) begin bad++; $display("FAIL restart_issue valid=%b addr=%h want 1/07", line_valid_o, line_addr_o); end
    total++; if (line_data_o !== exp) begin bad++; $display("FAIL restart_line got=%h want=%h", line_data_o, exp); end
    @(posedge clock_i); #1;
  endtask

  task automatic test_reset_issue();
    line_ready_i = 1'b0;
    put(8'h0C, 1'b1);
    for (int i = 0; i < LINE_BYTES; i++) put(8'h55, 1'b0);
    do_commit();
    total++; if (line_valid_o !== 1'b1) begin bad++; $display("FAIL ri_valid got=%b want=1", line_valid_o); end
    #2 reset_i = 1'b0;
    #1;
    total++; if (line_valid_o !== 1'b0) begin bad++; $display("FAIL ri_async_drop got=%b want=0", line_valid_o); end
    total++; if (overflow_o !== 1'b0) begin bad++; $display("FAIL ri_ovf_clear got=%b want=0", overflow_o); end
    @(posedge clock_i);
    @(negedge clock_i);
    reset_i = 1'b1;
    @(posedge clock_i); #1;
    total++; if (byte_ready_o !== 1'b1 || line_valid_o !== 1'b0) begin bad++; $display("FAIL ri_after ready=%b valid=%b want 1/0", byte_ready_o, line_valid_o); end
    total++; if (line_addr_o !== 8'h00 || line_data_o !== '0) begin bad++; $display("FAIL ri_regs addr=%h want=00 data=%h", line_addr_o, line_data_o); end
    total++; if ({commit_err_o, overflow_o} !== 2'b00) begin bad++; $display("FAIL ri_flags got=%b want=00", {commit_err_o, overflow_o}); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_commit_err();
    test_overflow();
    test_restart();
    test_reset_issue();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/icache_line_loader.md
Name: icache_line_loader

Overview:
- Single-clock cacheline loader that sits directly upstream of the instruction cache write port.
- Accepts a byte-serial stream: one destination-line address byte, then LINE_BYTES data bytes.
- Assembles the bytes into one cacheline and presents it to the i-cache with a valid/ready handshake.
- Replaces the separately clocked programming shift register, so the whole program-load path is synchronous to the core clock.

Parameters:
- LINE_BYTES, 32, number of data bytes per cacheline.
- LINE_W, LINE_BYTES*8 (256), cacheline width in bits.
- ADDR_W, 8, cacheline index width; taken from the address byte.

Ports:
- clock_i  in  1  core clock; all state changes on the rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- byte_valid_i  in  1  byte_data_i is presented this cycle.
- byte_data_i  in  8  address or data byte.
- is_address_i  in  1  qualifies the byte as the destination line address.
- commit_i  in  1  request to issue the assembled line to the i-cache.
- byte_ready_o  out  1  loader can accept a byte or a commit this cycle.
- line_valid_o  out  1  cacheline write request to the i-cache.
- line_ready_i  in  1  i-cache accepts the write.
- line_addr_o  out  ADDR_W  destination cacheline index.
- line_data_o  out  LINE_W  assembled cacheline.
- commit_err_o  out  1  one-cycle pulse: commit refused because the line is incomplete.
- overflow_o  out  1  sticky: a data byte arrived while the line was full.

Behaviour:
- Reset (reset_i low, asynchronous):
  - state=IDLE, byte count=0, line_addr_o=0, line_data_o=0.
  - line_valid_o=0, commit_err_o=0, overflow_o=0, byte_ready_o=1 once reset is released.
- A byte is accepted on an edge where byte_valid_i && byte_ready_o.
- A commit is accepted on an edge where commit_i && byte_ready_o.
- States and transitions:
  - IDLE: an accepted address byte loads line_addr_o, clears count and line_data_o, and goes to FILL. Data bytes in IDLE are ignored; no flag is raised.
  - FILL: an accepted data byte is written to line_data_o[8*count +: 8], then count is incremented. Byte 0 therefore lands in bits [7:0] (little-endian, lowest byte first). When count reaches LINE_BYTES, go to FULL.
  - FILL, address byte: restarts the fill. Loads the new address, clears count and data, stays in FILL.
  - FULL, data byte: discarded and overflow_o is set. overflow_o clears only on reset.
  - FULL, address byte: restarts the fill exactly as in FILL.
  - FULL, commit: go to ISSUE. line_valid_o is high from the edge that accepts the commit.
  - IDLE or FILL, commit: commit_err_o pulses for one cycle and the state is unchanged.
  - ISSUE: byte_ready_o=0. line_valid_o, line_addr_o and line_data_o are held stable until an edge with line_ready_i=1. On that edge the state returns to IDLE and line_valid_o drops.
- Latency:
  - Commit accepted at edge N gives line_valid_o=1 after edge N.
  - If line_ready_i=1 at that time, the transfer completes at edge N+1.
  - Minimum cost is 1+LINE_BYTES+1+1 cycles per line.
- Simultaneous inputs:
  - byte_valid_i with commit_i: the byte is processed first and the commit is ignored with no error pulse. The source must not do this; it is flagged in simulation with an assertion.
  - Address byte together with commit: the address wins.
- Reset mid-operation, including in ISSUE: abandons the line and drops line_valid_o immediately, asynchronously.
- line_data_o is not cleared on the return to IDLE. It changes only on the next address byte.
- The count register is 6 bits (holds 0..32) and never wraps. Overflow bytes do not modify the count.

Decomposition:
- Shared package pa_icache_pkg holds:
  - LINE_BYTES and LINE_W constants.
  - The loader_state_t enum (IDLE, FILL, FULL, ISSUE).
  - The cacheline_t typedef, shared with the i-cache.
- One sub-module is natural: line_byte_assembler, holding the byte-lane write-enable decode, data register and count. The FSM stays in icache_line_loader.

Test Plan:
- Address 0x03, data bytes 0x00..0x1F, commit with line_ready_i=1: line_valid_o high for exactly 1 cycle, line_addr_o=0x03, line_data_o[7:0]=0x00, line_data_o[255:248]=0x1F.
- Full line, then commit with line_ready_i=0 for 5 cycles then 1: valid held 6 cycles with data stable; byte_ready_o=0 throughout; IDLE after.
- Address 0x01, 10 bytes, commit: commit_err_o pulses once, line_valid_o stays 0. 22 more bytes then commit: line issued normally.
- 33 data bytes after an address: overflow_o=1 and stays 1; byte 33 is absent; the committed line equals bytes 1..32.
- Address 0x05, 20 bytes, address 0x07, 32 bytes, commit: line_addr_o=0x07, line_data_o holds only the second set of bytes.
- Assert reset_i=0 while in ISSUE mid-handshake: line_valid_o=0 without a clock edge; after release, byte_ready_o=1 and all outputs are at reset values.
